alu_32: RTL and testbench



---
 rtl/alu_32_if.sv | 30 +++
 rtl/alu_32.sv | 66 ++++++
 tb/tb_alu_32.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_32_if.sv
// alu_32_if -- operand/result bundle for the registered 32-bit ALU.
//   a, b      : 32-bit operands (two's complement when compared signed)
//   alucount  : 3-bit operation select
//   result    : registered 32-bit result
//   zero      : registered flag, 1 iff result == 0
// The master drives operands and control; the slave (the ALU) returns
// result and zero.
interface alu_32_if;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  alucount;
  logic [31:0] result;
  logic        zero;

  modport master (
    output a,
    output b,
    output alucount,
    input  result,
    input  zero
  );

  modport slave (
    input  a,
    input  b,
    input  alucount,
    output result,
    output zero
  );
endinterface

// File: rtl/alu_32.sv
// alu_32 -- registered 32-bit integer ALU with zero flag.
// Ports:
//   clk    : rising-edge clock; operands and control sampled here
//   reset  : asynchronous active-high; forces result = 0, zero = 1
//   bus    : alu_32_if.slave -- a, b, alucount in; result, zero out
// Operations (alucount):
//   000 AND, 001 OR, 010 ADD, 011 reserved (0),
//   100 AND-NOT, 101 OR-NOT, 110 SUB, 111 signed SLT.
// Latency is one cycle; a new operation may be issued every cycle.
module alu_32 (
  input  logic     clk,
  input  logic     reset,
  alu_32_if.slave  bus
);

  logic        [31:0] b_eff;
  logic               cin;
  logic signed [31:0] sum;
  logic               ovf;
  logic               lt;
  logic        [31:0] result_d;
  logic               zero_d;
  logic        [31:0] result_q;
  logic               zero_q;

  // alucount[2] turns the shared adder into a subtractor (a + ~b + 1)
  // and also selects the inverted-B logic operations.
  assign b_eff = bus.alucount[2] ? ~bus.b : bus.b;
  assign cin   = bus.alucount[2];
  assign sum   = $signed(bus.a + b_eff + {31'b0, cin});

  // Signed overflow of a - b: operands differ in sign and the difference
  // takes the sign of b. XOR with the sign bit gives a true signed a < b.
  assign ovf = (bus.a[31] != bus.b[31]) && (sum[31] != bus.a[31]);
  assign lt  = sum[31] ^ ovf;

  always_comb begin
    result_d = 32'h0;
    unique case (bus.alucount[1:0])
      2'b00:   result_d = bus.a & b_eff;
      2'b01:   result_d = bus.a | b_eff;
      2'b10:   result_d = sum;
      2'b11:   result_d = bus.alucount[2] ? {31'b0, lt} : 32'h0;
      default: result_d = 32'h0;
    endcase
  end

  // Zero is derived from the next-state result so it is registered in
  // step with result and never lags it.
  assign zero_d = ~|result_d;

  // ---- output register stage ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= 32'h0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_alu_32.sv
module tb_alu_32;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  alu_32_if bus ();

  alu_32 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation away from the active edge, clock it in, and
  // return just after the edge so outputs can be sampled.
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    @(negedge clk);
    bus.a        = a;
    bus.b        = b;
    bus.alucount = op;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    bus.a        = 32'h1234_5678;
    bus.b        = 32'h1111_1111;
    bus.alucount = 3'b010;
    #2;
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL reset_async: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL reset_hold: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_add();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] er [4];
    logic        ez [4];
    va = '{32'h0, 32'h0,        32'h1,        32'hff};
    vb = '{32'h0, 32'hffffffff, 32'hffffffff, 32'h1};
    er = '{32'h0, 32'hffffffff, 32'h0,        32'h100};
    ez = '{1'b1,  1'b0,         1'b1,         1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b010);
      n_total++;
      if (bus.result !== er[i] || bus.zero !== ez[i])
        $display("FAIL add[%0d]: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, er[i], ez[i]);
      else n_pass++;
    end
  endtask

  task automatic test_sub();
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] er [4];
    logic        ez [4];
    va = '{32'h0, 32'h0,        32'h1, 32'h100};
    vb = '{32'h0, 32'hffffffff, 32'h1, 32'h1};
    er = '{32'h0, 32'h1,        32'h0, 32'hff};
    ez = '{1'b1,  1'b0,         1'b1,  1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(va[i], vb[i], 3'b110);
      n_total++;
      if (bus.result !== er[i] || bus.zero !== ez[i])
        $display("FAIL sub[%0d]: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, er[i], ez[i]);
      else n_pass++;
    end
    // Borrow wrap: 0 - 1
    drive(32'h0, 32'h1, 3'b110);
    n_total++;
    if (bus.result !== 32'hffffffff || bus.zero !== 1'b0)
      $display("FAIL sub_wrap: result=%h zero=%b, want ffffffff 0", bus.result, bus.zero);
    else n_pass++;
  endtask

  task automatic test_slt();
    logic [31:0] va [7];
    logic [31:0] vb [7];
    logic [31:0] er [7];
    logic        ez [7];
    va = '{32'h0, 32'h0, 32'h0,        32'h1, 32'hffffffff, 32'h80000000, 32'h7fffffff};
    vb = '{32'h0, 32'h1, 32'hffffffff, 32'h0, 32'h0,        32'h7fffffff, 32'h80000000};
    er = '{32'h0, 32'h1, 32'h0,        32'h0, 32'h1,        32'h1,        32'h0};
    ez = '{1'b1,  1'b0,  1'b1,         1'b1,  1'b0,         1'b0,         1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(va[i], vb[i], 3'b111);
      n_total++;
      if (bus.result !== er[i] || bus.zero !== ez[i])
        $display("FAIL slt[%0d]: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, er[i], ez[i]);
      else n_pass++;
    end
  endtask

  task automatic test_logic();
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [2:0]  vo [5];
    logic [31:0] er [5];
    logic        ez [5];
    va = '{32'hffffffff, 32'h12345678, 32'h0,        32'h12345678, 32'h0};
    vb = '{32'h12345678, 32'h87654321, 32'hffffffff, 32'h87654321, 32'h0};
    vo = '{3'b000,       3'b000,       3'b000,       3'b001,       3'b001};
    er = '{32'h12345678, 32'h02244220, 32'h0,        32'h97755779, 32'h0};
    ez = '{1'b0,         1'b0,         1'b1,         1'b0,         1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(va[i], vb[i], vo[i]);
      n_total++;
      if (bus.result !== er[i] || bus.zero !== ez[i])
        $display("FAIL logic[%0d]: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, er[i], ez[i]);
      else n_pass++;
    end
  endtask

  task automatic test_inverted_b();
    logic [2:0]  vo [3];
    logic [31:0] er [3];
    logic        ez [3];
    vo = '{3'b100,       3'b101,       3'b011};
    er = '{32'h00f000f0, 32'hf0fff0ff, 32'h0};
    ez = '{1'b0,         1'b0,         1'b1};
    for (int i = 0; i < 3; i++) begin
      drive(32'hf0f0f0f0, 32'hff00ff00, vo[i]);
      n_total++;
      if (bus.result !== er[i] || bus.zero !== ez[i])
        $display("FAIL invb[%0d]: result=%h zero=%b, want %h %b", i, bus.result, bus.zero, er[i], ez[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_latency();
    drive(32'h5, 32'h3, 3'b010);
    n_total++;
    if (bus.result !== 32'h8 || bus.zero !== 1'b0)
      $display("FAIL add_5_3: result=%h zero=%b, want 00000008 0", bus.result, bus.zero);
    else n_pass++;
    // Assert reset between edges: outputs clear with no clock edge.
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL midstream_reset: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL reset_over_edge: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.result !== 32'h8 || bus.zero !== 1'b0)
      $display("FAIL post_reset_capture: result=%h zero=%b, want 00000008 0", bus.result, bus.zero);
    else n_pass++;
    // Inputs that would give 0 change between edges; outputs must hold.
    bus.a        = 32'h1;
    bus.b        = 32'h1;
    bus.alucount = 3'b110;
    #3;
    n_total++;
    if (bus.result !== 32'h8 || bus.zero !== 1'b0)
      $display("FAIL hold_between_edges: result=%h zero=%b, want 00000008 0", bus.result, bus.zero);
    else n_pass++;
    @(posedge clk);
    #1;
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL capture_after_hold: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Alternate results every cycle to catch stale or delayed outputs.
    drive(32'hffffffff, 32'h1, 3'b010);
    n_total++;
    if (bus.result !== 32'h0 || bus.zero !== 1'b1)
      $display("FAIL b2b_add_wrap: result=%h zero=%b, want 00000000 1", bus.result, bus.zero);
    else n_pass++;
    drive(32'h0000000a, 32'h00000003, 3'b110);
    n_total++;
    if (bus.result !== 32'h7 || bus.zero !== 1'b0)
      $display("FAIL b2b_sub: result=%h zero=%b, want 00000007 0", bus.result, bus.zero);
    else n_pass++;
    drive(32'hfffffffe, 32'hffffffff, 3'b111);
    n_total++;
    if (bus.result !== 32'h1 || bus.zero !== 1'b0)
      $display("FAIL b2b_slt_neg: result=%h zero=%b, want 00000001 0", bus.result, bus.zero);
    else n_pass++;
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    reset        = 1'b1;
    bus.a        = 32'h0;
    bus.b        = 32'h0;
    bus.alucount = 3'b000;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_inverted_b();
    test_reset_latency();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
